// File: rtl/adc_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eeg_acq_pkg
// Description : Types and constants shared by the ear-EEG acquisition path
//               (ADC frame sequencer and packetiser).
// Revision    : 1.0 - initial release
// ============================================================================
package eeg_acq_pkg;

   localparam int c_NUM_CH        = 8;
   localparam int c_SAMPLE_BITS   = 16;
   localparam int c_CONV_CYCLES   = 4;
   localparam int c_SETTLE_CYCLES = 8;
   localparam int c_FRAME_GAP     = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CONV   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_EMIT   = 3'd4,
      ST_GAP    = 3'd5
   } seq_state_t;

   // Channel index width; never narrower than one bit.
   function automatic int ch_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/adc_frame_sequencer_shifter.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_shifter
// Description : Serial-in / parallel-out capture register for one ADC word,
//               MSB first, with synchronous clear and shift enable.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_shifter #(
   parameter int SAMPLE_BITS = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   shift_en,
   input  logic                   sdi,
   output logic [SAMPLE_BITS-1:0] data
);

   // Shift the new bit in at the LSB so the first bit ends at the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
      end else if (clear) begin
         data <= '0;
      end else if (shift_en) begin
         data <= {data[SAMPLE_BITS-2:0], sdi};
      end
   end

endmodule
`default_nettype wire

// File: rtl/adc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_sequencer
// Description : Deterministic per-channel ADC acquisition schedule
//               (mux select, conversion strobe, settle, serial read) with a
//               single-entry valid/ready output stream and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_sequencer
   import eeg_acq_pkg::*;
#(
   parameter int NUM_CH        = c_NUM_CH,
   parameter int SAMPLE_BITS   = c_SAMPLE_BITS,
   parameter int CONV_CYCLES   = c_CONV_CYCLES,
   parameter int SETTLE_CYCLES = c_SETTLE_CYCLES,
   parameter int FRAME_GAP     = c_FRAME_GAP,
   localparam int CH_W         = ch_width(NUM_CH)
) (
   input  logic                   f_data_clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   adc_sdo,
   output logic                   adc_conv,
   output logic                   adc_read,
   output logic [CH_W-1:0]        ch_sel,
   output logic [SAMPLE_BITS-1:0] m_data,
   output logic [CH_W-1:0]        m_ch,
   output logic                   m_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic                   overflow
);

   localparam int c_MAX_A   = (CONV_CYCLES > SETTLE_CYCLES) ? CONV_CYCLES : SETTLE_CYCLES;
   localparam int c_MAX_B   = (SAMPLE_BITS > FRAME_GAP) ? SAMPLE_BITS : FRAME_GAP;
   localparam int c_CNT_MAX = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

   // Counter reload values: each phase runs for (load + 1) cycles.
   localparam logic [c_CNT_W-1:0] c_CONV_LD   = c_CNT_W'(CONV_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_SETTLE_LD = c_CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_SHIFT_LD  = c_CNT_W'(SAMPLE_BITS - 1);
   localparam logic [c_CNT_W-1:0] c_GAP_LD    = c_CNT_W'(FRAME_GAP - 1);
   localparam logic [CH_W-1:0]    c_LAST_CH   = CH_W'(NUM_CH - 1);

   seq_state_t             r_state;
   seq_state_t             w_state_next;
   logic [c_CNT_W-1:0]     r_cnt;
   logic [c_CNT_W-1:0]     w_cnt_next;
   logic                   w_emit;
   logic                   w_last_ch;
   logic [SAMPLE_BITS-1:0] w_shift_word;

   assign w_last_ch = (ch_sel == c_LAST_CH);
   assign adc_conv  = (r_state == ST_CONV);
   assign adc_read  = (r_state == ST_SHIFT);

   // Serial capture; cleared in IDLE so an aborted read never leaks out.
   adc_sample_shifter #(
      .SAMPLE_BITS (SAMPLE_BITS)
   ) u_shifter (
      .clk      (f_data_clk),
      .rst_n    (rst_n),
      .clear    (r_state == ST_IDLE),
      .shift_en (r_state == ST_SHIFT),
      .sdi      (adc_sdo),
      .data     (w_shift_word)
   );

   // State and shared phase counter registers.
   always_ff @(posedge f_data_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state logic; dropping enable aborts any phase back to IDLE.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_emit       = 1'b0;
      if ((r_state != ST_IDLE) && !enable) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable) begin
                  w_state_next = ST_CONV;
                  w_cnt_next   = c_CONV_LD;
               end
            end
            ST_CONV: begin
               if (r_cnt == '0) begin
                  w_state_next = ST_SETTLE;
                  w_cnt_next   = c_SETTLE_LD;
               end else begin
                  w_cnt_next = r_cnt - 1'b1;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == '0) begin
                  w_state_next = ST_SHIFT;
                  w_cnt_next   = c_SHIFT_LD;
               end else begin
                  w_cnt_next = r_cnt - 1'b1;
               end
            end
            ST_SHIFT: begin
               if (r_cnt == '0) begin
                  w_state_next = ST_EMIT;
               end else begin
                  w_cnt_next = r_cnt - 1'b1;
               end
            end
            ST_EMIT: begin
               w_emit = 1'b1;
               if (w_last_ch && (FRAME_GAP > 0)) begin
                  w_state_next = ST_GAP;
                  w_cnt_next   = c_GAP_LD;
               end else begin
                  w_state_next = ST_CONV;
                  w_cnt_next   = c_CONV_LD;
               end
            end
            ST_GAP: begin
               if (r_cnt == '0) begin
                  w_state_next = ST_CONV;
                  w_cnt_next   = c_CONV_LD;
               end else begin
                  w_cnt_next = r_cnt - 1'b1;
               end
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Mux select advances after EMIT so the next channel settles through CONV+SETTLE.
   always_ff @(posedge f_data_clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_sel <= '0;
      end else if (w_state_next == ST_IDLE) begin
         ch_sel <= '0;
      end else if (w_emit) begin
         ch_sel <= w_last_ch ? '0 : ch_sel + 1'b1;
      end
   end

   // Output stream register: newest sample wins, overflow is sticky until IDLE.
   always_ff @(posedge f_data_clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data   <= '0;
         m_ch     <= '0;
         m_last   <= 1'b0;
         m_valid  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (w_emit) begin
            m_data  <= w_shift_word;
            m_ch    <= ch_sel;
            m_last  <= w_last_ch;
            m_valid <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
         if (r_state == ST_IDLE) begin
            overflow <= 1'b0;
         end else if (w_emit && m_valid && !m_ready) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire
